voice_allocator: RTL

// Polyphonic voice scheduler between midi_receive and a bank of additive_synth voices.

---
 rtl/voice_allocator.sv | 127 ++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler mapping MIDI note events onto NUM_VOICES voice slots
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   din_valid             strobe: status/data1/data2 hold one complete MIDI message
//   status, data1, data2  message body (status MSB stripped, channel ignored)
//   busy                  an accepted event is being scanned or committed
//   event_dropped         pulse: event discarded (arrived while busy, or no voice available)
//   voice_active          bit i = voice i sounding
//   voice_note, voice_vel 7 bits per voice, voice i at [7i+6:7i]
//   voice_update          pulse per voice whose active/note/vel was written
// Build option: define VOICE_STEAL_EN to let a NOTE_ON steal the oldest voice when none is free.
module voice_allocator #(
   parameter int NUM_VOICES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    din_valid,
   input  logic [6:0]              status,
   input  logic [6:0]              data1,
   input  logic [6:0]              data2,
   output logic                    busy,
   output logic                    event_dropped,
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic [7*NUM_VOICES-1:0] voice_note,
   output logic [7*NUM_VOICES-1:0] voice_vel,
   output logic [NUM_VOICES-1:0]   voice_update
);
   localparam int IW = $clog2(NUM_VOICES);
   localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2;
   localparam logic [1:0] K_NONE = 2'd0, K_ON = 2'd1, K_OFF = 2'd2, K_ALL = 2'd3;
   localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
   logic [1:0]    state, kind, kind_in;
   logic [IW-1:0] idx, match_idx, free_idx, old_idx, old_age, tgt;
   logic          match_found, free_found, old_found, hit, cur_active;
   logic [6:0]    ev_note, ev_vel, cur_note;
   logic [IW-1:0] age [NUM_VOICES];
   assign busy = state != IDLE;
   assign cur_active = voice_active[idx];
   assign cur_note = voice_note[7*idx +: 7];
   assign kind_in = (status[6:4] == 3'b001 && data2 != 7'd0) ? K_ON :
                    (status[6:4] <= 3'b001) ? K_OFF :
                    (status[6:4] == 3'b011 && data1 == 7'd123) ? K_ALL : K_NONE;
   assign tgt = match_found ? match_idx : free_found ? free_idx : old_idx;
`ifdef VOICE_STEAL_EN
   assign hit = match_found | free_found | old_found;
`else
   assign hit = match_found | free_found;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx <= '0;
         kind <= K_NONE;
         ev_note <= '0;
         ev_vel <= '0;
         match_found <= 1'b0;
         free_found <= 1'b0;
         old_found <= 1'b0;
         match_idx <= '0;
         free_idx <= '0;
         old_idx <= '0;
         old_age <= '0;
         event_dropped <= 1'b0;
         voice_active <= '0;
         voice_note <= '0;
         voice_vel <= '0;
         voice_update <= '0;
         for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
      end else begin
         event_dropped <= din_valid & busy;
         voice_update <= '0;
         if (state == IDLE) begin
            if (din_valid) begin
               state <= SCAN;
               idx <= '0;
               kind <= kind_in;
               ev_note <= data1;
               ev_vel <= data2;
               match_found <= 1'b0;
               free_found <= 1'b0;
               old_found <= 1'b0;
            end
         end else if (state == SCAN) begin
            idx <= idx + 1'b1;
            if (idx == LAST) state <= COMMIT;
            if (cur_active && cur_note == ev_note && !match_found) begin
               match_found <= 1'b1;
               match_idx <= idx;
            end
            if (!cur_active && !free_found) begin
               free_found <= 1'b1;
               free_idx <= idx;
            end
            // strict compare keeps the lowest index among equally old voices
            if (cur_active && (!old_found || age[idx] > old_age)) begin
               old_found <= 1'b1;
               old_idx <= idx;
               old_age <= age[idx];
            end
         end else begin
            state <= IDLE;
            if (kind == K_ON) begin
               if (hit) begin
                  for (int i = 0; i < NUM_VOICES; i++)
                     if (IW'(i) == tgt) begin
                        voice_active[i] <= 1'b1;
                        voice_note[7*i +: 7] <= ev_note;
                        voice_vel[7*i +: 7] <= ev_vel;
                        age[i] <= '0;
                        voice_update[i] <= 1'b1;
                     end else if (voice_active[i] && age[i] != LAST) age[i] <= age[i] + 1'b1;
               end else event_dropped <= 1'b1;
            end else if (kind == K_OFF && match_found) begin
               voice_active[match_idx] <= 1'b0;
               age[match_idx] <= '0;
               voice_update[match_idx] <= 1'b1;
            end else if (kind == K_ALL) begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  voice_active[i] <= 1'b0;
                  age[i] <= '0;
                  voice_update[i] <= voice_active[i];
               end
            end
         end
      end
   end
endmodule
